// File: rtl/set_assoc_cache_pkg.sv
// Shared types and width helpers for the set-associative write-back cache.
// Optional hit/miss counters are enabled with CACHE_STATS_EN.
package set_assoc_cache_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FILL      = 2'd2,
        S_INSTALL   = 2'd3
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int way_w(input int ways);
        return (ways > 1) ? clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/set_assoc_cache_lru.sv
// Per-set LRU ages for the cache: victim selection and MRU update.
// Ages form a permutation of 0..WAYS-1 per set; 0 is most recently used.
module cache_lru
    import set_assoc_cache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int SETS  = 32,
    parameter int IDX_W = 5,
    parameter int WAY_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] index,
    input  logic [WAY_W-1:0] access_way,
    input  logic             update,
    input  logic [WAYS-1:0]  valid_vec,
    output logic [WAY_W-1:0] victim_way
);

    generate
        if (WAYS == 1) begin : g_dm
            logic w_unused;
            assign w_unused   = ^{clk, rst, index, access_way, update, valid_vec};
            assign victim_way = '0;
        end else begin : g_lru
            logic [WAY_W-1:0] r_age [SETS][WAYS];
            logic [WAY_W-1:0] w_old;
            logic [WAY_W-1:0] w_inv_way;
            logic [WAY_W-1:0] w_max_way;
            logic             w_has_inv;

            assign w_old = r_age[index][access_way];

            // Descending scan so the lowest invalid way wins.
            always_comb begin
                w_has_inv = 1'b0;
                w_inv_way = '0;
                w_max_way = '0;
                for (int w = WAYS - 1; w >= 0; w--) begin
                    if (!valid_vec[w]) begin
                        w_has_inv = 1'b1;
                        w_inv_way = WAY_W'(w);
                    end
                end
                for (int w = 1; w < WAYS; w++) begin
                    if (r_age[index][w] > r_age[index][w_max_way])
                        w_max_way = WAY_W'(w);
                end
            end

            assign victim_way = w_has_inv ? w_inv_way : w_max_way;

            // Reset to the identity permutation so ages stay distinct.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < SETS; s++)
                        for (int w = 0; w < WAYS; w++)
                            r_age[s][w] <= WAY_W'(w);
                end else if (update) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (WAY_W'(w) == access_way)
                            r_age[index][w] <= '0;
                        else if (r_age[index][w] < w_old)
                            r_age[index][w] <= r_age[index][w] + 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back, write-allocate data cache with LRU.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module set_assoc_cache
    import set_assoc_cache_pkg::*;
#(
    parameter int WAYS   = 2,
    parameter int SETS   = 32,
    parameter int WORDS  = 4,
    parameter int MEM_AW = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           addr,
    input  logic                  re,
    input  logic                  we,
    input  logic [31:0]           din,
    output logic [31:0]           dout,
    output logic                  complete,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [32*WORDS-1:0]   mem_wdata,
    input  logic [32*WORDS-1:0]   mem_rdata,
    input  logic                  mem_complete
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int OFF_W = clog2(WORDS);
    localparam int IDX_W = clog2(SETS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam int WAY_W = way_w(WAYS);
    localparam int BLK_W = 32 * WORDS;

    logic             r_valid [WAYS][SETS];
    logic             r_dirty [WAYS][SETS];
    logic [TAG_W-1:0] r_tags  [WAYS][SETS];
    logic [BLK_W-1:0] r_data  [WAYS][SETS];

    state_t           r_state;
    state_t           w_next;
    logic [WAY_W-1:0] r_victim;
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic [BLK_W-1:0] r_fill;

    logic [OFF_W-1:0] w_off;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_req;
    logic             w_hit;
    logic [WAY_W-1:0] w_hit_way;
    logic [WAYS-1:0]  w_valid_vec;
    logic [WAY_W-1:0] w_victim;
    logic [BLK_W-1:0] w_hit_blk;
    logic             w_lru_upd;
    logic             w_unused;

    assign w_off     = addr[OFF_W+1:2];
    assign w_idx     = addr[OFF_W+2 +: IDX_W];
    assign w_tag     = addr[31 -: TAG_W];
    assign w_req     = re | we;
    assign w_unused  = ^addr[1:0];
    assign w_hit_blk = r_data[w_hit_way][w_idx];
    assign w_lru_upd = (r_state == S_IDLE) && w_req && w_hit;

    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_valid_vec = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_valid_vec[w] = r_valid[w][w_idx];
            if (!w_hit && r_valid[w][w_idx] && r_tags[w][w_idx] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    cache_lru #(
        .WAYS  (WAYS),
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .WAY_W (WAY_W)
    ) u_lru (
        .clk        (clk),
        .rst        (rst),
        .index      (w_idx),
        .access_way (w_hit_way),
        .update     (w_lru_upd),
        .valid_vec  (w_valid_vec),
        .victim_way (w_victim)
    );

    always_comb begin
        w_next    = r_state;
        complete  = 1'b0;
        dout      = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        complete = 1'b1;
                        if (!we) dout = w_hit_blk[{w_off, 5'b0} +: 32];
                    end else if (r_valid[w_victim][w_idx] &&
                                 r_dirty[w_victim][w_idx]) begin
                        w_next = S_WRITEBACK;
                    end else begin
                        w_next = S_FILL;
                    end
                end
            end
            S_WRITEBACK: begin
                mem_we    = 1'b1;
                mem_addr  = MEM_AW'({r_tags[r_victim][r_idx], r_idx});
                mem_wdata = r_data[r_victim][r_idx];
                if (mem_complete) w_next = S_FILL;
            end
            S_FILL: begin
                mem_re   = 1'b1;
                mem_addr = MEM_AW'({r_tag, r_idx});
                if (mem_complete) w_next = S_INSTALL;
            end
            S_INSTALL: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    r_valid[w][s] <= 1'b0;
                    r_dirty[w][s] <= 1'b0;
                end
            end
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE:
                    if (w_req && w_hit && we)
                        r_dirty[w_hit_way][w_idx] <= 1'b1;
                S_WRITEBACK:
                    if (mem_complete)
                        r_dirty[r_victim][r_idx] <= 1'b0;
                S_FILL: ;
                S_INSTALL: begin
                    r_valid[r_victim][r_idx] <= 1'b1;
                    r_dirty[r_victim][r_idx] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Arrays and miss context carry no reset; only valid bits gate them.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_req && !w_hit) begin
            r_victim <= w_victim;
            r_idx    <= w_idx;
            r_tag    <= w_tag;
        end
        if (r_state == S_FILL && mem_complete)
            r_fill <= mem_rdata;
        if (!rst) begin
            if (r_state == S_IDLE && w_req && w_hit && we)
                r_data[w_hit_way][w_idx][{w_off, 5'b0} +: 32] <= din;
            if (r_state == S_INSTALL) begin
                r_tags[r_victim][r_idx] <= r_tag;
                r_data[r_victim][r_idx] <= r_fill;
            end
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (r_state == S_IDLE && w_req) begin
            if (w_hit && hit_count != '1)
                hit_count <= hit_count + 1'b1;
            if (!w_hit && miss_count != '1)
                miss_count <= miss_count + 1'b1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache with a behavioural block-memory responder.
// The responder completes each memory transfer two cycles after the request.
module tb_set_assoc_cache;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr;
    logic         re;
    logic         we;
    logic [31:0]  din;
    logic [31:0]  dout;
    logic         complete;
    logic         mem_re;
    logic         mem_we;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_complete;
`ifdef CACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    always #5 clk = ~clk;

    set_assoc_cache dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .re           (re),
        .we           (we),
        .din          (din),
        .dout         (dout),
        .complete     (complete),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_complete (mem_complete)
`ifdef CACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [127:0] mem_img [int];
    logic [31:0]  acc_rdata;
    int           acc_cycles;
    int           fill_cnt;
    int           wb_cnt;
    logic [27:0]  fill_addr;
    logic [27:0]  wb_addr;
    logic [31:0]  wb_word1;
    bit           both_seen = 1'b0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pat_blk(input logic [27:0] blk);
        logic [127:0] b;
        for (int i = 0; i < 4; i++)
            b[i*32 +: 32] = 32'hA000_0000 | (32'(blk[15:0]) << 8) | 32'(i);
        return b;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        re  = 1'b0;
        we  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; returns at a negedge with the request dropped.
    task automatic access(input logic [31:0] a, input logic r, input logic w,
                          input logic [31:0] d);
        int wait_c;
        bit done;
        addr = a; re = r; we = w; din = d;
        acc_cycles = 0; fill_cnt = 0; wb_cnt = 0;
        wait_c = 0; done = 1'b0; acc_rdata = '0;
        while (!done && acc_cycles < 40) begin
            #1;
            if (mem_re && mem_we) both_seen = 1'b1;
            if (complete) begin
                acc_rdata = dout;
                done = 1'b1;
            end else if (mem_re || mem_we) begin
                wait_c++;
                if (mem_re)
                    mem_rdata = mem_img.exists(int'(mem_addr)) ?
                                mem_img[int'(mem_addr)] : pat_blk(mem_addr);
                if (wait_c == 2) begin
                    wait_c = 0;
                    mem_complete = 1'b1;
                    if (mem_we) begin
                        wb_cnt++;
                        wb_addr  = mem_addr;
                        wb_word1 = mem_wdata[63:32];
                        mem_img[int'(mem_addr)] = mem_wdata;
                    end else begin
                        fill_cnt++;
                        fill_addr = mem_addr;
                    end
                end
            end
            @(posedge clk);
            @(negedge clk);
            mem_complete = 1'b0;
            if (!done) acc_cycles++;
        end
        re = 1'b0;
        we = 1'b0;
        if (!done) check("access_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1; addr = '0; re = 1'b0; we = 1'b0; din = '0;
        mem_rdata = '0; mem_complete = 1'b0;
        @(negedge clk);
        do_reset();

        #1;
        check("rst_complete", complete, 0);
        check("rst_mem_re", mem_re, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_dout", dout, 0);
        @(negedge clk);

        access(32'h100, 1, 0, 0);
        check("cold_rdata", acc_rdata, 32'hA000_1000);
        check("cold_fill_addr", fill_addr, 28'h10);
        check("cold_fill_cnt", fill_cnt, 1);
        check("cold_latency", acc_cycles, 4);
        access(32'h100, 1, 0, 0);
        check("rehit_latency", acc_cycles, 0);
        check("rehit_fill_cnt", fill_cnt, 0);
        check("rehit_rdata", acc_rdata, 32'hA000_1000);
        access(32'h108, 1, 0, 0);
        check("word2_rdata", acc_rdata, 32'hA000_1002);

        access(32'h104, 0, 1, 32'hDEAD_BEEF);
        check("whit_latency", acc_cycles, 0);
        check("whit_wb_cnt", wb_cnt, 0);
        access(32'h104, 1, 0, 0);
        check("whit_readback", acc_rdata, 32'hDEAD_BEEF);
        check("whit_no_wb", wb_cnt, 0);

        do_reset();
        access(32'h104, 0, 1, 32'hDEAD_BEEF);
        check("wmiss_latency", acc_cycles, 4);
        check("wmiss_wb_cnt", wb_cnt, 0);
        access(32'h304, 1, 0, 0);
        check("set16_way1_rdata", acc_rdata, 32'hA000_3001);
        check("set16_way1_wb", wb_cnt, 0);
        access(32'h504, 1, 0, 0);
        check("evict_wb_cnt", wb_cnt, 1);
        check("evict_wb_addr", wb_addr, 28'h10);
        check("evict_wb_word1", wb_word1, 32'hDEAD_BEEF);
        check("evict_fill_addr", fill_addr, 28'h50);
        check("evict_rdata", acc_rdata, 32'hA000_5001);
        check("evict_latency", acc_cycles, 6);
        access(32'h104, 1, 0, 0);
        check("refill_wb_cnt", wb_cnt, 0);
        check("refill_rdata", acc_rdata, 32'hDEAD_BEEF);

        do_reset();
        access(32'h100, 1, 0, 0);
        access(32'h300, 1, 0, 0);
        access(32'h100, 1, 0, 0);
        check("lru_hit_100", acc_cycles, 0);
        access(32'h500, 1, 0, 0);
        check("lru_no_wb", wb_cnt, 0);
        check("lru_fill_addr", fill_addr, 28'h50);
        access(32'h100, 1, 0, 0);
        check("lru_keep_100", acc_cycles, 0);
        access(32'h300, 1, 0, 0);
        check("lru_evicted_300", acc_cycles, 4);

        do_reset();
        addr = 32'h100; re = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("fill1_mem_re", mem_re, 1);
        @(posedge clk);
        @(negedge clk);
        check("fill2_mem_re", mem_re, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        re  = 1'b0;
        #1;
        check("midrst_mem_re", mem_re, 0);
        check("midrst_complete", complete, 0);
        mem_complete = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_complete = 1'b0;
        #1;
        check("late_pulse_mem_re", mem_re, 0);
        @(negedge clk);
        access(32'h100, 1, 0, 0);
        check("midrst_remiss", fill_cnt, 1);
        check("midrst_rdata", acc_rdata, 32'hA000_1000);

        do_reset();
        access(32'h0, 1, 1, 32'h5);
        check("rw_both_rdata", acc_rdata, 0);
        access(32'h0, 1, 0, 0);
        check("rw_both_readback", acc_rdata, 32'h5);
        check("never_re_we", both_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
